// File: rtl/tree_ni_flit_injector_pkg.sv
// Shared types and flit-layout helpers for the tree NoC endpoint flit injector.
package tree_ni_pkg;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        IDLE       = 2'd1,
        SEND       = 2'd2
    } ni_state_e;

    // Flit layout: {head, tail, vc_onehot[V-1:0], payload[Fpay-1:0]}
    function automatic int head_bit(input int v, input int fpay);
        return fpay + v + 1;
    endfunction

    function automatic int tail_bit(input int v, input int fpay);
        return fpay + v;
    endfunction

    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

    function automatic int pay_lsb();
        return 0;
    endfunction

    function automatic logic [63:0] head_payload(input logic [31:0] dest,
                                                 input logic [31:0] src,
                                                 input logic [31:0] len,
                                                 input int          raw,
                                                 input int          lenw);
        logic [63:0] amask;
        logic [63:0] lmask;
        amask = (64'd1 << raw) - 64'd1;
        lmask = (64'd1 << lenw) - 64'd1;
        return ({32'd0, dest} & amask)
             | (({32'd0, src} & amask) << raw)
             | (({32'd0, len} & lmask) << (2 * raw));
    endfunction

endpackage

// File: rtl/tree_ni_flit_injector_if.sv
// Request and fabric-side signals of one endpoint injector; slave is the injector side.
interface tree_ni_flit_injector_if
    import tree_ni_pkg::*;
#(
    parameter int V           = 4,
    parameter int Fpay        = 32,
    parameter int RAw         = 8,
    parameter int MAX_PKT_LEN = 8
);
    localparam int LENw = $clog2(MAX_PKT_LEN + 1);
    localparam int VCw  = (V > 1) ? $clog2(V) : 1;
    localparam int Fw   = 2 + V + Fpay;

    logic             req_valid;
    logic             req_ready;
    logic [RAw-1:0]   req_dest;
    logic [LENw-1:0]  req_len;
    logic [VCw-1:0]   req_vc;
    logic [Fw-1:0]    flit_out;
    logic             flit_out_wr;
    logic [V-1:0]     credit_in;

    modport slave (
        input  req_valid, req_dest, req_len, req_vc, credit_in,
        output req_ready, flit_out, flit_out_wr
    );

    modport master (
        output req_valid, req_dest, req_len, req_vc, credit_in,
        input  req_ready, flit_out, flit_out_wr
    );
endinterface

// File: rtl/tree_ni_flit_injector_credit_counter.sv
// Per-VC credit counter: starts full at B, decrements on issue, increments on return.
module ni_credit_counter
    import tree_ni_pkg::*;
#(
    parameter int B     = 4,
    parameter int V     = 4,
    parameter int VC_ID = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [V-1:0]             issue_i,
    input  logic [V-1:0]             return_i,
    output logic [$clog2(B+1)-1:0]   count_o,
    output logic                     nonzero_o,
    output logic                     err_o
);
    localparam int          CNTW = $clog2(B + 1);
    localparam logic [V-1:0] SEL = V'(1) << VC_ID;

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic            iss;
    logic            ret;
    logic            full;

    assign iss  = |(issue_i & SEL);
    assign ret  = |(return_i & SEL);
    assign full = (count_q == CNTW'(B));

    // A return that would push past B is dropped and reported instead.
    always_comb begin
        count_d = count_q;
        if (iss && !ret) begin
            count_d = count_q - CNTW'(1);
        end else if (ret && !iss && !full) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= CNTW'(B);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);
    assign err_o     = ret && !iss && full;

endmodule

// File: rtl/tree_ni_flit_injector.sv
// Endpoint injector: segments packet requests into head/body/tail flits under per-VC credit flow control.
module tree_ni_flit_injector
    import tree_ni_pkg::*;
#(
    parameter int V           = 4,
    parameter int Fpay        = 32,
    parameter int B           = 4,
    parameter int RAw         = 8,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [RAw-1:0]              src_addr,
    tree_ni_flit_injector_if.slave      bus,
    output logic [31:0]                 pkt_sent_cnt,
    output logic                        credit_err
);
    localparam int LENw   = $clog2(MAX_PKT_LEN + 1);
    localparam int VCw    = (V > 1) ? $clog2(V) : 1;
    localparam int Fw     = 2 + V + Fpay;
    localparam int CNTW   = $clog2(B + 1);
    localparam int HEAD_B = head_bit(V, Fpay);
    localparam int TAIL_B = tail_bit(V, Fpay);
    localparam int VC_LSB = vc_lsb(Fpay);
    localparam int PAYLSB = pay_lsb();

    ni_state_e       state_q, state_d;
    logic [RAw-1:0]  dest_q, dest_d;
    logic [LENw-1:0] len_q, len_d;
    logic [VCw-1:0]  vc_q, vc_d;
    logic [LENw-1:0] idx_q, idx_d;
    logic [Fw-1:0]   flit_q, flit_d;
    logic            wr_q, wr_d;
    logic            ready_q, ready_d;
    logic [31:0]     pkt_q, pkt_d;
    logic            err_q, err_d;

    logic [V-1:0]    issue_vec;
    logic [V-1:0]    cred_nz;
    logic [V-1:0]    cred_err;
    logic [CNTW-1:0] cred_cnt [V];
    logic [Fpay-1:0] payload;
    logic            last;

    function automatic logic [LENw-1:0] clamp_len(input logic [LENw-1:0] l);
        if (l == '0) return LENw'(1);
        if (int'(l) > MAX_PKT_LEN) return LENw'(MAX_PKT_LEN);
        return l;
    endfunction

    for (genvar g = 0; g < V; g++) begin : g_cred
        ni_credit_counter #(.B(B), .V(V), .VC_ID(g)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .issue_i   (issue_vec),
            .return_i  (bus.credit_in),
            .count_o   (cred_cnt[g]),
            .nonzero_o (cred_nz[g]),
            .err_o     (cred_err[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        len_d     = len_q;
        vc_d      = vc_q;
        idx_d     = idx_q;
        flit_d    = flit_q;
        wr_d      = 1'b0;
        pkt_d     = pkt_q;
        issue_vec = '0;
        payload   = '0;
        last      = 1'b0;

        unique case (state_q)
            WAIT_START: begin
                if (start_i) state_d = IDLE;
            end
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    dest_d  = bus.req_dest;
                    len_d   = clamp_len(bus.req_len);
                    vc_d    = bus.req_vc;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cred_nz[vc_q]) begin
                    last = (idx_q == len_q - LENw'(1));
                    if (idx_q == '0) begin
                        payload = Fpay'(head_payload(32'(dest_q), 32'(src_addr), 32'(len_q), RAw, LENw));
                    end else begin
                        payload = {pkt_q[Fpay-LENw-1:0], idx_q};
                    end
                    issue_vec[vc_q]          = 1'b1;
                    wr_d                     = 1'b1;
                    flit_d                   = '0;
                    flit_d[HEAD_B]           = (idx_q == '0);
                    flit_d[TAIL_B]           = last;
                    flit_d[VC_LSB +: V]      = V'(1) << vc_q;
                    flit_d[PAYLSB +: Fpay]   = payload;
                    idx_d                    = idx_q + LENw'(1);
                    if (last) begin
                        state_d = IDLE;
                        pkt_d   = pkt_q + 32'd1;
                    end
                end
            end
            default: state_d = WAIT_START;
        endcase

        ready_d = (state_d == IDLE);
        err_d   = err_q | (|cred_err);
    end

    // Control and output registers: cleared asynchronously, so a reset aborts any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_START;
            flit_q  <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    // Packet context is always rewritten on accept before it is read.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        len_q  <= len_d;
        vc_q   <= vc_d;
        idx_q  <= idx_d;
    end

    assign bus.req_ready   = ready_q;
    assign bus.flit_out    = flit_q;
    assign bus.flit_out_wr = wr_q;
    assign pkt_sent_cnt    = pkt_q;
    assign credit_err      = err_q;

endmodule
